fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction driven into IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall_i  input  1  hazard-unit hold: freeze PC and IF/ID.
REQ-006 flush_i  input  1  squash IF/ID contents (bubble insert).
REQ-007 redirect_i  input  1  taken branch/jump resolved downstream.
REQ-008 redirect_pc_i  input  32  redirect target address.
REQ-009 imem_addr_o  output  32  instruction memory address (current PC).
REQ-010 imem_req_o  output  1  fetch request valid.
REQ-011 imem_rdata_i  input  32  instruction word for imem_addr_o, same cycle.
REQ-012 imem_ready_i  input  1  imem_rdata_i valid this cycle.
REQ-013 if_pc_o  output  32  IF/ID registered PC.
REQ-014 if_pc4_o  output  32  IF/ID registered PC+4.
REQ-015 if_instr_o  output  32  IF/ID registered instruction, feeds decode/immediate generation.
REQ-016 if_valid_o  output  1  IF/ID holds a real instruction.

Function
REQ-017 FSM states BOOT, RUN, WAIT; shall occupy BOOT for exactly one cycle after rst_n deasserts.
REQ-018 In BOOT: imem_req_o=0; PC held at RESET_PC; IF/ID loads bubble; next state RUN.
REQ-019 In RUN/WAIT: imem_req_o=1; imem_addr_o=PC (combinational from PC register).
REQ-020 RUN->WAIT when imem_ready_i=0 and redirect_i=0; WAIT->RUN when imem_ready_i=1 or redirect_i=1.
REQ-021 Next-PC priority: redirect_i -> {redirect_pc_i[31:2],2'b00}; else stall_i or imem_ready_i=0 -> hold PC; else PC+4.
REQ-022 PC+4 shall be 32-bit modular: 32'hFFFF_FFFC wraps to 32'h0000_0000; if_pc4_o wraps identically.
REQ-023 IF/ID priority: flush_i or redirect_i -> bubble; else stall_i -> hold all four IF/ID outputs; else imem_ready_i=1 -> load {PC, PC+4, imem_rdata_i, valid=1}; else bubble.
REQ-024 Bubble = if_instr_o=NOP_INSTR, if_valid_o=0, if_pc_o/if_pc4_o hold prior value.
REQ-025 flush_i with stall_i: flush wins; IF/ID becomes bubble while PC follows REQ-021.
REQ-026 redirect_i with stall_i: redirect wins for both PC and IF/ID.
REQ-027 Fetch-to-IF/ID latency exactly 1 cycle; sustained throughput one instruction per cycle when imem_ready_i=1 and no stall.
REQ-028 imem_rdata_i captured only when imem_ready_i=1; no instruction word shall be duplicated or skipped across stall/WAIT intervals.

Reset
REQ-029 rst_n=0 sampled at a clock edge shall force: PC=RESET_PC, state=BOOT, if_valid_o=0, if_instr_o=NOP_INSTR, if_pc_o=0, if_pc4_o=0.
REQ-030 Reset mid-WAIT or mid-stall shall discard pending fetch; rst_n overrides stall_i, flush_i, redirect_i.
REQ-031 Outputs shall change only on clock edges except imem_addr_o/imem_req_o (combinational from registers).

Verification
REQ-032 Reset release, imem_ready_i=1, memory word=addr: BOOT 1 cycle, then if_pc_o 0,4,8 with if_instr_o 0,4,8 and if_valid_o=1 on consecutive cycles.
REQ-033 stall_i=1 for 2 cycles while if_pc_o=8: if_pc_o/if_instr_o hold at 8 for 2 extra cycles, then 12 follows; no duplicate.
REQ-034 redirect_i=1 with redirect_pc_i=32'h0000_0103 at PC=16: next cycle if_valid_o=0, imem_addr_o=32'h0000_0100; following cycle if_pc_o=0x100.
REQ-035 imem_ready_i=0 for 3 cycles at PC=20: state WAIT, bubbles (valid=0, NOP_INSTR) for 3 cycles, PC held 20, then if_pc_o=20.
REQ-036 RESET_PC=32'hFFFF_FFFC: second fetched if_pc_o=0, if_pc4_o=4 after first if_pc4_o=0.
REQ-037 rst_n=0 asserted during stall+WAIT: next edge all outputs equal REQ-029 values, BOOT re-entered.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: PC register, fetch FSM (BOOT/RUN/WAIT) and IF/ID register; 1-cycle fetch-to-IF/ID latency.
// Backpressure: stall_i freezes PC and IF/ID; imem_ready_i low holds PC and inserts bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] if_pc_d, if_pc4_d, if_instr_d;
  logic        if_valid_d;
  logic        unused_redirect_lsbs;

  // Redirect targets are word aligned; the low bits are dropped.
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign imem_addr_o = pc_q;
  assign imem_req_o  = (state_q != BOOT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_o;
    if_pc4_d   = if_pc4_o;
    if_instr_d = if_instr_o;
    if_valid_d = if_valid_o;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
      RUN, WAIT: begin
        if (state_q == RUN && !imem_ready_i && !redirect_i)
          state_d = WAIT;
        else if (state_q == WAIT && (imem_ready_i || redirect_i))
          state_d = RUN;

        if (redirect_i)
          pc_d = {redirect_pc_i[31:2], 2'b00};
        else if (stall_i || !imem_ready_i)
          pc_d = pc_q;
        else
          pc_d = pc_plus4;

        // Flush/redirect beat stall; a bubble keeps the previous PC fields.
        if (flush_i || redirect_i) begin
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
        end else if (stall_i) begin
          if_valid_d = if_valid_o;
        end else if (imem_ready_i) begin
          if_pc_d    = pc_q;
          if_pc4_d   = pc_plus4;
          if_instr_d = imem_rdata_i;
          if_valid_d = 1'b1;
        end else begin
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_o    <= 32'd0;
      if_pc4_o   <= 32'd0;
      if_instr_o <= NOP_INSTR;
      if_valid_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_o    <= if_pc_d;
      if_pc4_o   <= if_pc4_d;
      if_instr_o <= if_instr_d;
      if_valid_o <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default-reset instance plus a wrap-around instance, memory word = address.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, redirect, ready;
  logic [31:0] redirect_pc;
  logic [31:0] addr, rdata, if_pc, if_pc4, if_instr;
  logic        req, if_valid;
  logic [31:0] addr_w, rdata_w, if_pc_w, if_pc4_w, if_instr_w;
  logic        req_w, if_valid_w;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign rdata   = addr;
  assign rdata_w = addr_w;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(addr), .imem_req_o(req), .imem_rdata_i(rdata), .imem_ready_i(ready),
    .if_pc_o(if_pc), .if_pc4_o(if_pc4), .if_instr_o(if_instr), .if_valid_o(if_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(addr_w), .imem_req_o(req_w), .imem_rdata_i(rdata_w), .imem_ready_i(ready),
    .if_pc_o(if_pc_w), .if_pc4_o(if_pc4_w), .if_instr_o(if_instr_w), .if_valid_o(if_valid_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; ready = 1'b1;
    tick(); tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", if_instr, NOP); end
    checks++; if (if_pc !== 32'd0 || if_pc4 !== 32'd0) begin errors++; $display("FAIL reset_ifpc got %h/%h exp 0/0", if_pc, if_pc4); end
    checks++; if (addr !== 32'd0 || req !== 1'b0) begin errors++; $display("FAIL reset_imem got %h/%b exp 0/0", addr, req); end
    rst_n = 1'b1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", req); end
    tick();
    checks++; if (req !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL boot_exit got req=%b valid=%b exp 1/0", req, if_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i * 4);
      tick();
      checks++;
      if (if_pc !== exp_pc || if_instr !== exp_pc || if_valid !== 1'b1 || if_pc4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL seq%0d got pc=%h instr=%h pc4=%h v=%b exp pc=instr=%h", i, if_pc, if_instr, if_pc4, if_valid, exp_pc);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (if_pc !== 32'd8 || if_instr !== 32'd8 || if_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got pc=%h instr=%h v=%b exp 8/8/1", i, if_pc, if_instr, if_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_pc !== 32'd12 || if_instr !== 32'd12) begin errors++; $display("FAIL stall_release got %h/%h exp c/c", if_pc, if_instr); end
  endtask

  task automatic test_redirect();
    tick();
    checks++; if (if_pc !== 32'd16 || addr !== 32'd20) begin errors++; $display("FAIL pre_redirect got %h/%h exp 10/14", if_pc, addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP || addr !== 32'h100 || if_pc !== 32'd16) begin
      errors++; $display("FAIL redirect_bubble got v=%b instr=%h addr=%h pc=%h exp 0/%h/100/10", if_valid, if_instr, addr, if_pc, NOP);
    end
    redirect = 1'b0;
    tick();
    checks++; if (if_pc !== 32'h100 || if_instr !== 32'h100 || if_valid !== 1'b1) begin errors++; $display("FAIL redirect_fetch got %h/%h/%b exp 100/100/1", if_pc, if_instr, if_valid); end
  endtask

  task automatic test_wait();
    redirect = 1'b1; redirect_pc = 32'd20;
    tick();
    redirect = 1'b0; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b0 || if_instr !== NOP || addr !== 32'd20 || req !== 1'b1 || if_pc !== 32'h100) begin
        errors++; $display("FAIL wait_bubble%0d got v=%b instr=%h addr=%h req=%b pc=%h", i, if_valid, if_instr, addr, req, if_pc);
      end
    end
    ready = 1'b1;
    tick();
    checks++; if (if_pc !== 32'd20 || if_instr !== 32'd20 || if_valid !== 1'b1) begin errors++; $display("FAIL wait_resume got %h/%h/%b exp 14/14/1", if_pc, if_instr, if_valid); end
  endtask

  task automatic test_flush_stall();
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP || addr !== 32'd24 || if_pc !== 32'd20) begin
      errors++; $display("FAIL flush_stall got v=%b instr=%h addr=%h pc=%h exp 0/%h/18/14", if_valid, if_instr, addr, if_pc, NOP);
    end
    flush = 1'b0; stall = 1'b0;
    tick();
    checks++; if (if_pc !== 32'd24 || if_instr !== 32'd24 || if_valid !== 1'b1) begin errors++; $display("FAIL flush_resume got %h/%h/%b exp 18/18/1", if_pc, if_instr, if_valid); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0202;
    tick();
    checks++; if (addr !== 32'h200 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_stall got addr=%h v=%b exp 200/0", addr, if_valid); end
    stall = 1'b0; redirect = 1'b0;
    tick();
    checks++; if (if_pc !== 32'h200 || if_pc4 !== 32'h204 || if_instr !== 32'h200) begin errors++; $display("FAIL redir_stall_fetch got %h/%h/%h exp 200/204/200", if_pc, if_pc4, if_instr); end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1; ready = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || addr !== 32'h204) begin errors++; $display("FAIL stall_wait_hold got v=%b pc=%h addr=%h exp 1/200/204", if_valid, if_pc, addr); end
    rst_n = 1'b0; flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    checks++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'd0 || if_pc4 !== 32'd0 || addr !== 32'd0 || req !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b instr=%h pc=%h pc4=%h addr=%h req=%b", if_valid, if_instr, if_pc, if_pc4, addr, req);
    end
    checks++; if (addr_w !== 32'hFFFF_FFFC || req_w !== 1'b0) begin errors++; $display("FAIL wrap_reset got %h/%b exp fffffffc/0", addr_w, req_w); end
    rst_n = 1'b1; flush = 1'b0; redirect = 1'b0; stall = 1'b0; ready = 1'b1;
    tick();
    checks++; if (req !== 1'b1 || if_valid !== 1'b0 || addr !== 32'd0) begin errors++; $display("FAIL reboot got req=%b v=%b addr=%h exp 1/0/0", req, if_valid, addr); end
  endtask

  task automatic test_wrap();
    tick();
    checks++; if (if_pc_w !== 32'hFFFF_FFFC || if_pc4_w !== 32'd0 || if_instr_w !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first got %h/%h/%h exp fffffffc/0/fffffffc", if_pc_w, if_pc4_w, if_instr_w);
    end
    checks++; if (if_pc !== 32'd0 || if_valid !== 1'b1) begin errors++; $display("FAIL reboot_fetch got %h/%b exp 0/1", if_pc, if_valid); end
    tick();
    checks++; if (if_pc_w !== 32'd0 || if_pc4_w !== 32'd4 || if_valid_w !== 1'b1) begin
      errors++; $display("FAIL wrap_second got %h/%h/%b exp 0/4/1", if_pc_w, if_pc4_w, if_valid_w);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wait();
    test_flush_stall();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
